// File: rtl/vc_rr_arbiter.sv
// Round-robin merge of NUM_PORTS credit-based slave ports onto one valid/ready master port.
// Each slave owns a CREDIT_NUM-deep buffer and a private credit-return pulse.
module vc_rr_arbiter #(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CREDIT_NUM = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data_i,
   input  logic [NUM_PORTS-1:0]            s_valid_i,
   output logic [NUM_PORTS-1:0]            s_credit_o,
   output logic [DATA_WIDTH-1:0]           m_data_o,
   output logic [$clog2(NUM_PORTS)-1:0]    m_id_o,
   output logic                            m_valid_o,
   input  logic                            m_ready_i,
   output logic [NUM_PORTS-1:0]            ovf_err_o
);

   localparam int unsigned ID_WIDTH = $clog2(NUM_PORTS);
   localparam int unsigned CNT_W    = $clog2(CREDIT_NUM + 1);
   localparam int unsigned PTR_W    = (CREDIT_NUM > 1) ? $clog2(CREDIT_NUM) : 1;

   logic [DATA_WIDTH-1:0] mem_q [NUM_PORTS][CREDIT_NUM];
   logic [PTR_W-1:0]      wr_ptr_q [NUM_PORTS];
   logic [PTR_W-1:0]      wr_ptr_d [NUM_PORTS];
   logic [PTR_W-1:0]      rd_ptr_q [NUM_PORTS];
   logic [PTR_W-1:0]      rd_ptr_d [NUM_PORTS];
   logic [CNT_W-1:0]      cnt_q    [NUM_PORTS];
   logic [CNT_W-1:0]      cnt_d    [NUM_PORTS];
   logic [CNT_W-1:0]      pend_q   [NUM_PORTS];
   logic [CNT_W-1:0]      pend_d   [NUM_PORTS];

   logic [NUM_PORTS-1:0] credit_q, credit_d;
   logic [NUM_PORTS-1:0] ovf_q, ovf_d;
   logic [ID_WIDTH-1:0]  arb_ptr_q, arb_ptr_d;
   logic                 lock_q, lock_d;
   logic [ID_WIDTH-1:0]  lock_id_q, lock_id_d;

   logic [NUM_PORTS-1:0] req, push, pop;
   logic [ID_WIDTH-1:0]  grant;
   logic                 found;
   logic                 hs;

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         req[i] = (cnt_q[i] != '0);
      end
   end

   // Locked grant overrides the search so a stalled beat cannot be pre-empted.
   always_comb begin
      int unsigned idx;
      found = 1'b0;
      grant = '0;
      idx   = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = (int'(arb_ptr_q) + k) % NUM_PORTS;
         if (!found && req[idx]) begin
            found = 1'b1;
            grant = ID_WIDTH'(idx);
         end
      end
      if (lock_q) begin
         grant = lock_id_q;
      end
   end

   assign m_valid_o  = |req;
   assign m_id_o     = m_valid_o ? grant : '0;
   assign m_data_o   = m_valid_o ? mem_q[grant][rd_ptr_q[grant]] : '0;
   assign hs         = m_valid_o && m_ready_i;
   assign s_credit_o = credit_q;
   assign ovf_err_o  = ovf_q;

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         pop[i]  = hs && (grant == ID_WIDTH'(i));
         push[i] = s_valid_i[i] && ((cnt_q[i] != CNT_W'(CREDIT_NUM)) || pop[i]);
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      credit_d = '0;
      ovf_d    = ovf_q | (s_valid_i & ~push);
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (push[i]) begin
            wr_ptr_d[i] = (wr_ptr_q[i] == PTR_W'(CREDIT_NUM - 1)) ? '0 : wr_ptr_q[i] + PTR_W'(1);
         end
         if (pop[i]) begin
            rd_ptr_d[i] = (rd_ptr_q[i] == PTR_W'(CREDIT_NUM - 1)) ? '0 : rd_ptr_q[i] + PTR_W'(1);
         end
         cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
         credit_d[i] = (pend_q[i] != '0);
         pend_d[i]   = pend_q[i] + CNT_W'(pop[i]) - CNT_W'(pend_q[i] != '0);
      end
   end

   always_comb begin
      arb_ptr_d = arb_ptr_q;
      if (hs) begin
         arb_ptr_d = (grant == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + ID_WIDTH'(1);
      end
      lock_d    = m_valid_o && !m_ready_i;
      lock_id_d = grant;
   end

   // Beat storage carries no reset; occupancy counters gate every read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= s_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
            pend_q[i]   <= CNT_W'(CREDIT_NUM);
         end
         credit_q  <= '0;
         ovf_q     <= '0;
         arb_ptr_q <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         credit_q  <= credit_d;
         ovf_q     <= ovf_d;
         arb_ptr_q <= arb_ptr_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

endmodule

// File: tb/tb_vc_rr_arbiter.sv
// Directed bench for vc_rr_arbiter: expected master beats are queued as stimulus is driven and
// checked by a negedge monitor, which also tracks grant stability and credit accounting.
module tb_vc_rr_arbiter;

   localparam int unsigned NP = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned CN = 2;

   logic           clk;
   logic           rst;
   logic [NP*DW-1:0] s_data;
   logic [NP-1:0]  s_valid;
   logic [NP-1:0]  s_credit;
   logic [DW-1:0]  m_data;
   logic [1:0]     m_id;
   logic           m_valid;
   logic           m_ready;
   logic [NP-1:0]  ovf_err;

   vc_rr_arbiter #(
      .NUM_PORTS  (NP),
      .DATA_WIDTH (DW),
      .CREDIT_NUM (CN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .s_data_i   (s_data),
      .s_valid_i  (s_valid),
      .s_credit_o (s_credit),
      .m_data_o   (m_data),
      .m_id_o     (m_id),
      .m_valid_o  (m_valid),
      .m_ready_i  (m_ready),
      .ovf_err_o  (ovf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]    id;
      logic [DW-1:0] data;
   } beat_t;

   beat_t exp_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    credit_cnt [NP];
   int    pop_cnt    [NP];

   logic          have_prev;
   logic          prev_valid, prev_ready;
   logic [1:0]    prev_id;
   logic [DW-1:0] prev_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Monitor: scoreboard pop on handshake, stability while stalled, credit counting.
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            credit_cnt[i] = 0;
            pop_cnt[i]    = 0;
         end
         have_prev = 1'b0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (s_credit[i]) credit_cnt[i]++;
         end
         if (have_prev && prev_valid && !prev_ready) begin
            chk("lock_valid", 32'(m_valid), 32'd1);
            chk("lock_id", 32'(m_id), 32'(prev_id));
            chk("lock_data", 32'(m_data), 32'(prev_data));
         end
         if (m_valid && m_ready) begin
            pop_cnt[m_id]++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
               n_err++;
               $error("FAIL sb_unexpected: observed id %0d data %0h expected no beat", m_id, m_data);
            end
            if (exp_q.size() != 0) begin
               beat_t e;
               e = exp_q.pop_front();
               chk("sb_id", 32'(m_id), 32'(e.id));
               chk("sb_data", 32'(m_data), 32'(e.data));
            end
         end
         have_prev  = 1'b1;
         prev_valid = m_valid;
         prev_ready = m_ready;
         prev_id    = m_id;
         prev_data  = m_data;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input logic [1:0] id, input logic [DW-1:0] d);
      beat_t b;
      b.id   = id;
      b.data = d;
      exp_q.push_back(b);
   endtask

   task automatic drive(input logic [NP-1:0] v, input logic [NP*DW-1:0] d);
      s_valid = v;
      s_data  = d;
   endtask

   task automatic check_credits();
      for (int i = 0; i < NP; i++) begin
         chk($sformatf("credits_port%0d", i), 32'(credit_cnt[i]), 32'(CN + pop_cnt[i]));
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_data"}, 32'(m_data), 32'd0);
      chk({tag, "_id"}, 32'(m_id), 32'd0);
      chk({tag, "_credit"}, 32'(s_credit), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf_err), 32'd0);
   endtask

   // Release happens just after a posedge; credits must be high on the 1st and 2nd following cycles.
   task automatic check_credit_init(input string tag);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("%s_credit_c%0d", tag, k), 32'(s_credit),
             (k == 1 || k == 2) ? 32'hF : 32'h0);
         chk($sformatf("%s_valid_c%0d", tag, k), 32'(m_valid), 32'd0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      s_valid = '0;
      s_data  = '0;
      m_ready = 1'b0;
      cyc(2);

      // Reset state and credit initialisation with no traffic.
      check_zero_outputs("reset");
      rst = 1'b0;
      check_credit_init("init");
      check_credits();

      // Port 2 pushes two beats back to back with the master ready.
      m_ready = 1'b1;
      drive(4'b0100, {8'h00, 8'hA1, 8'h00, 8'h00});
      expect_beat(2'd2, 8'hA1);
      @(negedge clk);
      chk("no_bypass", 32'(m_valid), 32'd0);
      cyc(1);
      drive(4'b0100, {8'h00, 8'hA2, 8'h00, 8'h00});
      expect_beat(2'd2, 8'hA2);
      @(negedge clk);
      chk("p2_first_valid", 32'(m_valid), 32'd1);
      chk("p2_first_id", 32'(m_id), 32'd2);
      cyc(1);
      drive(4'b0000, '0);
      @(negedge clk);
      chk("p2_second_valid", 32'(m_valid), 32'd1);
      chk("p2_second_data", 32'(m_data), 32'hA2);
      cyc(5);
      chk("p2_drained", 32'(m_valid), 32'd0);
      check_credits();
      chk("p2_sb_empty", 32'(exp_q.size()), 32'd0);

      // All four ports push at once: ids 0..3 on consecutive cycles.
      do_reset();
      drive(4'b1111, {8'h13, 8'h12, 8'h11, 8'h10});
      for (int i = 0; i < NP; i++) expect_beat(2'(i), 8'(8'h10 + i));
      cyc(1);
      drive(4'b0000, '0);
      for (int k = 0; k < NP; k++) begin
         @(negedge clk);
         chk($sformatf("all_valid_c%0d", k), 32'(m_valid), 32'd1);
         chk($sformatf("all_id_c%0d", k), 32'(m_id), 32'(k));
      end
      cyc(2);
      chk("all_drained", 32'(m_valid), 32'd0);
      // Pointer is back at 0, so port 0 must win over port 3.
      drive(4'b1001, {8'h23, 8'h00, 8'h00, 8'h20});
      expect_beat(2'd0, 8'h20);
      expect_beat(2'd3, 8'h23);
      cyc(1);
      drive(4'b0000, '0);
      cyc(5);
      check_credits();
      chk("all_sb_empty", 32'(exp_q.size()), 32'd0);

      // Stall with ports 1 and 3 loaded while port 0 arrives later.
      do_reset();
      m_ready = 1'b0;
      drive(4'b1010, {8'h33, 8'h00, 8'h31, 8'h00});
      cyc(1);
      drive(4'b0001, {8'h00, 8'h00, 8'h00, 8'h30});
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("stall_id_c%0d", k), 32'(m_id), 32'd1);
         chk($sformatf("stall_data_c%0d", k), 32'(m_data), 32'h31);
         chk($sformatf("stall_credit_c%0d", k), 32'(s_credit), 32'd0);
         cyc(1);
         drive(4'b0000, '0);
      end
      expect_beat(2'd1, 8'h31);
      expect_beat(2'd3, 8'h33);
      expect_beat(2'd0, 8'h30);
      m_ready = 1'b1;
      cyc(6);
      check_credits();
      chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);

      // Overflow on port 0; port 1 traffic must still get through.
      do_reset();
      m_ready = 1'b0;
      drive(4'b0001, {8'h00, 8'h00, 8'h00, 8'h50});
      cyc(1);
      drive(4'b0001, {8'h00, 8'h00, 8'h00, 8'h51});
      cyc(1);
      drive(4'b0011, {8'h00, 8'h00, 8'h61, 8'h52});
      cyc(1);
      drive(4'b0000, '0);
      @(negedge clk);
      chk("ovf_set", 32'(ovf_err), 32'h1);
      cyc(3);
      chk("ovf_sticky", 32'(ovf_err), 32'h1);
      expect_beat(2'd0, 8'h50);
      expect_beat(2'd1, 8'h61);
      expect_beat(2'd0, 8'h51);
      m_ready = 1'b1;
      cyc(6);
      chk("ovf_after_drain", 32'(ovf_err), 32'h1);
      chk("ovf_drained", 32'(m_valid), 32'd0);
      check_credits();
      chk("ovf_sb_empty", 32'(exp_q.size()), 32'd0);

      // Reset with beats buffered: outputs clear at once, beats discarded, credits re-issued.
      m_ready = 1'b0;
      drive(4'b1100, {8'h73, 8'h62, 8'h00, 8'h00});
      cyc(1);
      drive(4'b0000, '0);
      @(negedge clk);
      chk("pre_rst_valid", 32'(m_valid), 32'd1);
      cyc(1);
      rst = 1'b1;
      #1;
      check_zero_outputs("midrst");
      cyc(1);
      rst = 1'b0;
      check_credit_init("rerun");
      m_ready = 1'b1;
      cyc(3);
      chk("post_rst_empty", 32'(m_valid), 32'd0);
      check_credits();
      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
